// File: rtl/clkgen_pkg.sv
// Shared types and constants for the PLL-lock supervisor / domain reset sequencer.
package clkgen_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } seq_state_e;

   localparam logic [7:0]  RETRY_SAT = 8'hFF;
   localparam logic [15:0] LOSS_SAT  = 16'hFFFF;

   // One spare bit over the largest terminal count so no wrap is ever reachable.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Per-bit flop chain bringing the asynchronous PLL lock indicators into clk.
module lock_synchronizer #(
   parameter int WIDTH  = 2,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
      end else begin
         r_stage[0] <= i_async;
         for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
      end
   end

   assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// PLL reset / lock supervision and staggered release of downstream domain resets.
//
// state     | meaning
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | pll_rst low, waiting for all locks, retry on timeout
// SETTLE    | all locks must stay high for SETTLE_CYCLES consecutive cycles
// RELEASE   | domain resets dropped one by one, STAGGER_CYCLES apart
// RUN       | everything released; any lock drop restarts the sequence
module clock_reset_sequencer
   import clkgen_pkg::*;
#(
   parameter int NUM_PLLS       = 2,
   parameter int NUM_DOMAINS    = 4,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES = 8,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PLLS-1:0]    pll_lock,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   all_ready,
   output logic [7:0]             retry_count,
   output logic [15:0]            lock_loss_count,
   output logic [2:0]             state_dbg
);

   localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, STAGGER_CYCLES);
   localparam logic [CW-1:0] TC_PLL_RST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TC_TIMEOUT = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] TC_SETTLE  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TC_STAGGER = CW'(STAGGER_CYCLES - 1);
   localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = '1;
   localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = DOM_ALL << 1;

   seq_state_e             r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_pll_rst;
   logic [NUM_DOMAINS-1:0] r_domain_rst;
   logic                   r_all_ready;
   logic [7:0]             r_retry;
   logic [15:0]            r_loss;

   logic [NUM_PLLS-1:0]    w_lock_sync;
   logic                   w_locked;
   logic [NUM_DOMAINS-1:0] w_dom_shift;

   lock_synchronizer #(
      .WIDTH  (NUM_PLLS),
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (pll_lock),
      .o_sync  (w_lock_sync)
   );

   assign w_locked    = &w_lock_sync;
   assign w_dom_shift = r_domain_rst << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= PLL_RESET;
         r_cnt        <= '0;
         r_pll_rst    <= 1'b1;
         r_domain_rst <= DOM_ALL;
         r_all_ready  <= 1'b0;
         r_retry      <= '0;
         r_loss       <= '0;
      end else if ((r_state == RELEASE || r_state == RUN) && !w_locked) begin
         // Lock loss outranks any release scheduled on the same edge.
         r_state      <= PLL_RESET;
         r_cnt        <= '0;
         r_pll_rst    <= 1'b1;
         r_domain_rst <= DOM_ALL;
         r_all_ready  <= 1'b0;
         if (r_loss != LOSS_SAT) r_loss <= r_loss + 16'd1;
      end else begin
         case (r_state)
            PLL_RESET: begin
               if (r_cnt == TC_PLL_RST) begin
                  r_state   <= WAIT_LOCK;
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (w_locked) begin
                  r_state <= SETTLE;
                  r_cnt   <= '0;
               end else if (r_cnt == TC_TIMEOUT) begin
                  r_state   <= PLL_RESET;
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b1;
                  if (r_retry != RETRY_SAT) r_retry <= r_retry + 8'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (!w_locked) begin
                  r_state <= WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (r_cnt == TC_SETTLE) begin
                  r_cnt        <= '0;
                  r_domain_rst <= DOM_FIRST;
                  if (NUM_DOMAINS == 1) begin
                     r_state     <= RUN;
                     r_all_ready <= 1'b1;
                  end else begin
                     r_state <= RELEASE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (r_cnt == TC_STAGGER) begin
                  r_cnt        <= '0;
                  r_domain_rst <= w_dom_shift;
                  if (w_dom_shift == '0) begin
                     r_state     <= RUN;
                     r_all_ready <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RUN: r_cnt <= '0;
            default: begin
               r_state      <= PLL_RESET;
               r_cnt        <= '0;
               r_pll_rst    <= 1'b1;
               r_domain_rst <= DOM_ALL;
               r_all_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst         = r_pll_rst;
   assign domain_rst      = r_domain_rst;
   assign all_ready       = r_all_ready;
   assign retry_count     = r_retry;
   assign lock_loss_count = r_loss;
   assign state_dbg       = r_state;

endmodule
